// File: rtl/sdram_read_arbiter.sv
// Two-client round-robin read arbiter in front of a single Avalon-MM SDRAM port.
// One read is outstanding at a time; a watchdog abandons reads whose data never returns.

module sdram_read_arbiter_checker #(
   parameter int ADDR_W = 26
) (
   input logic              clock,
   input logic              reset_n,
   input logic              req0_valid,
   input logic [ADDR_W-1:0] req0_addr,
   input logic              req0_ack,
   input logic              req1_valid,
   input logic [ADDR_W-1:0] req1_addr,
   input logic              req1_ack
);

   // A request may only be withdrawn in the cycle its ack is visible
   a_req0_hold: assert property (@(posedge clock) disable iff (!reset_n)
      $fell(req0_valid) |-> req0_ack);
   a_req1_hold: assert property (@(posedge clock) disable iff (!reset_n)
      $fell(req1_valid) |-> req1_ack);

   // The address of a pending request must not move before it is acknowledged
   a_req0_addr: assert property (@(posedge clock) disable iff (!reset_n)
      ($past(req0_valid) && req0_valid && !req0_ack) |-> $stable(req0_addr));
   a_req1_addr: assert property (@(posedge clock) disable iff (!reset_n)
      ($past(req1_valid) && req1_valid && !req1_ack) |-> $stable(req1_addr));

endmodule

module sdram_read_arbiter #(
   parameter int ADDR_W         = 26,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ack,
   output logic              rsp0_valid,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ack,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [7:0]        timeout_count,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [1:0]        sdram_byteenable_n,
   output logic              sdram_chipselect,
   output logic [DATA_W-1:0] sdram_writedata,
   output logic              sdram_read_n,
   output logic              sdram_write_n,
   input  logic [DATA_W-1:0] sdram_readdata,
   input  logic              sdram_readdata_valid,
   input  logic              sdram_waitrequest
);

   localparam logic [1:0]  ST_IDLE      = 2'd0;
   localparam logic [1:0]  ST_ISSUE     = 2'd1;
   localparam logic [1:0]  ST_WAIT_DATA = 2'd2;
   localparam logic [1:0]  ST_RESPOND   = 2'd3;
   localparam logic [15:0] WDOG_LAST    = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]        state_r;
   logic              last_grant_r;
   logic              grant_r;
   logic [15:0]       wdog_r;
   logic [ADDR_W-1:0] sdram_addr_r;
   logic              read_n_r;
   logic              chipselect_r;
   logic              req0_ack_r;
   logic              req1_ack_r;
   logic              rsp0_valid_r;
   logic              rsp1_valid_r;
   logic [DATA_W-1:0] rsp_data_r;
   logic              rsp_err_r;
   logic [7:0]        timeout_count_r;
   logic              any_req_s;
   logic              pick_s;

   // Round-robin choice: a lone requester wins, a tie goes to whoever was not served last
   always_comb begin
      any_req_s = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         pick_s = ~last_grant_r;
      end else begin
         pick_s = req1_valid;
      end
   end

   // Transaction sequencer: grant, hold the command through stalls, collect data or time out
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= ST_IDLE;
         last_grant_r    <= 1'b1;
         grant_r         <= 1'b0;
         wdog_r          <= 16'd0;
         sdram_addr_r    <= {ADDR_W{1'b0}};
         read_n_r        <= 1'b1;
         chipselect_r    <= 1'b0;
         req0_ack_r      <= 1'b0;
         req1_ack_r      <= 1'b0;
         rsp0_valid_r    <= 1'b0;
         rsp1_valid_r    <= 1'b0;
         rsp_data_r      <= {DATA_W{1'b0}};
         rsp_err_r       <= 1'b0;
         timeout_count_r <= 8'd0;
      end else begin
         req0_ack_r   <= 1'b0;
         req1_ack_r   <= 1'b0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  state_r      <= ST_ISSUE;
                  grant_r      <= pick_s;
                  last_grant_r <= pick_s;
                  sdram_addr_r <= pick_s ? req1_addr : req0_addr;
                  read_n_r     <= 1'b0;
                  chipselect_r <= 1'b1;
                  req0_ack_r   <= ~pick_s;
                  req1_ack_r   <= pick_s;
               end
            end
            ST_ISSUE: begin
               // Avalon forbids dropping a stalled command, so no watchdog runs here
               if (!sdram_waitrequest) begin
                  read_n_r     <= 1'b1;
                  chipselect_r <= 1'b0;
                  wdog_r       <= 16'd0;
                  if (sdram_readdata_valid) begin
                     rsp_data_r   <= sdram_readdata;
                     rsp_err_r    <= 1'b0;
                     rsp0_valid_r <= ~grant_r;
                     rsp1_valid_r <= grant_r;
                     state_r      <= ST_RESPOND;
                  end else begin
                     state_r <= ST_WAIT_DATA;
                  end
               end
            end
            ST_WAIT_DATA: begin
               if (sdram_readdata_valid) begin
                  rsp_data_r   <= sdram_readdata;
                  rsp_err_r    <= 1'b0;
                  rsp0_valid_r <= ~grant_r;
                  rsp1_valid_r <= grant_r;
                  state_r      <= ST_RESPOND;
               end else if (wdog_r == WDOG_LAST) begin
                  rsp_data_r   <= {DATA_W{1'b0}};
                  rsp_err_r    <= 1'b1;
                  rsp0_valid_r <= ~grant_r;
                  rsp1_valid_r <= grant_r;
                  state_r      <= ST_RESPOND;
                  if (timeout_count_r != 8'hFF) begin
                     timeout_count_r <= timeout_count_r + 8'd1;
                  end
               end else begin
                  wdog_r <= wdog_r + 16'd1;
               end
            end
            ST_RESPOND: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r      <= ST_IDLE;
               read_n_r     <= 1'b1;
               chipselect_r <= 1'b0;
            end
         endcase
      end
   end

   assign req0_ack           = req0_ack_r;
   assign req1_ack           = req1_ack_r;
   assign rsp0_valid         = rsp0_valid_r;
   assign rsp1_valid         = rsp1_valid_r;
   assign rsp_data           = rsp_data_r;
   assign rsp_err            = rsp_err_r;
   assign timeout_count      = timeout_count_r;
   assign sdram_addr         = sdram_addr_r;
   assign sdram_read_n       = read_n_r;
   assign sdram_chipselect   = chipselect_r;
   assign sdram_write_n      = 1'b1;
   assign sdram_byteenable_n = 2'b00;
   assign sdram_writedata    = {DATA_W{1'b0}};

   sdram_read_arbiter_checker #(.ADDR_W(ADDR_W)) u_checker (
      .clock      (clock),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_ack   (req0_ack_r),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_ack   (req1_ack_r)
   );

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Bench for sdram_read_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_sdram_read_arbiter;

   localparam int TO = 4;
   typedef logic [75:0] ovec_t;

   typedef struct {
      logic        r0;
      logic [25:0] a0;
      logic        r1;
      logic [25:0] a1;
      logic        wr;
      logic        rdv;
      logic [15:0] rd;
      ovec_t       exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req0_valid, req1_valid;
   logic [25:0] req0_addr, req1_addr;
   logic        req0_ack, req1_ack, rsp0_valid, rsp1_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic [7:0]  timeout_count;
   logic [25:0] sdram_addr;
   logic [1:0]  sdram_byteenable_n;
   logic        sdram_chipselect, sdram_read_n, sdram_write_n;
   logic [15:0] sdram_writedata, sdram_readdata;
   logic        sdram_readdata_valid, sdram_waitrequest;

   int n_checks = 0;
   int n_pass   = 0;

   // reference-model state: owner of the outstanding read and its progress
   int          m_last, m_owner, m_age;
   bit          m_cmd, m_reply;
   logic        m_ack0, m_ack1, m_rn, m_cs, m_v0, m_v1, m_err;
   logic [25:0] m_addr;
   logic [15:0] m_data;
   logic [7:0]  m_tc;

   always #5 clock = ~clock;

   sdram_read_arbiter #(.ADDR_W(26), .DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ack(req0_ack), .rsp0_valid(rsp0_valid),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ack(req1_ack), .rsp1_valid(rsp1_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .timeout_count(timeout_count),
      .sdram_addr(sdram_addr), .sdram_byteenable_n(sdram_byteenable_n),
      .sdram_chipselect(sdram_chipselect), .sdram_writedata(sdram_writedata),
      .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n),
      .sdram_readdata(sdram_readdata), .sdram_readdata_valid(sdram_readdata_valid),
      .sdram_waitrequest(sdram_waitrequest)
   );

   function automatic ovec_t mk(logic a0, logic a1, logic rn, logic cs, logic [25:0] ad,
                                logic v0, logic v1, logic [15:0] d, logic e, logic [7:0] tc);
      return {a0, a1, rn, cs, ad, v0, v1, d, e, tc, 1'b1, 2'b00, 16'h0000};
   endfunction

   function automatic ovec_t actual();
      return {req0_ack, req1_ack, sdram_read_n, sdram_chipselect, sdram_addr, rsp0_valid,
              rsp1_valid, rsp_data, rsp_err, timeout_count, sdram_write_n,
              sdram_byteenable_n, sdram_writedata};
   endfunction

   task automatic check(string name, ovec_t exp);
      ovec_t act;
      act = actual();
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: outputs %h, expected %h", name, act, exp);
   endtask

   task automatic check_int(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic drive(logic r0, logic [25:0] a0, logic r1, logic [25:0] a1,
                        logic wr, logic rdv, logic [15:0] rd);
      req0_valid = r0; req0_addr = a0; req1_valid = r1; req1_addr = a1;
      sdram_waitrequest = wr; sdram_readdata_valid = rdv; sdram_readdata = rd;
   endtask

   task automatic do_reset();
      drive(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
      @(negedge clock); reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock); reset_n = 1'b1;
   endtask

   task automatic model_reset();
      m_last = 1; m_owner = -1; m_age = 0; m_cmd = 1'b0; m_reply = 1'b0;
      m_ack0 = 1'b0; m_ack1 = 1'b0; m_rn = 1'b1; m_cs = 1'b0; m_v0 = 1'b0; m_v1 = 1'b0;
      m_err = 1'b0; m_addr = 26'h0; m_data = 16'h0; m_tc = 8'd0;
   endtask

   task automatic model_finish(logic [15:0] d, logic e);
      m_data = d; m_err = e; m_reply = 1'b1;
      if (m_owner == 0) m_v0 = 1'b1; else m_v1 = 1'b1;
   endtask

   // Advance the model by one clock: one read in flight, handed back to whoever asked for it
   task automatic model_step(bit r0, bit r1, logic [25:0] a0, logic [25:0] a1,
                             bit wr, bit rdv, logic [15:0] rd);
      int w;
      m_ack0 = 1'b0; m_ack1 = 1'b0; m_v0 = 1'b0; m_v1 = 1'b0;
      if (m_reply) begin
         m_reply = 1'b0; m_owner = -1;
      end else if (m_owner < 0) begin
         if (r0 || r1) begin
            w = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
            m_last = w; m_owner = w; m_cmd = 1'b1;
            m_addr = (w == 1) ? a1 : a0;
            m_rn = 1'b0; m_cs = 1'b1;
            if (w == 1) m_ack1 = 1'b1; else m_ack0 = 1'b1;
         end
      end else if (m_cmd) begin
         if (!wr) begin
            m_cmd = 1'b0; m_rn = 1'b1; m_cs = 1'b0; m_age = 0;
            if (rdv) model_finish(rd, 1'b0);
         end
      end else if (rdv) begin
         model_finish(rd, 1'b0);
      end else if (m_age + 1 >= TO) begin
         model_finish(16'h0, 1'b1);
         if (m_tc != 8'hFF) m_tc = m_tc + 8'd1;
      end else begin
         m_age++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [7];
      int          grants [$];
      int          guard;
      bit          r0h, r1h, p0, p1, wr, rdv;
      logic [25:0] ra0, ra1;
      logic [15:0] rd;
      ovec_t       rst_v;

      rst_v = mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0, 1'b0, 8'd0);
      tbl[0] = '{r0:1'b1, a0:26'h0000123, r1:1'b0, a1:26'h0, wr:1'b0, rdv:1'b0, rd:16'h0,
                 exp:mk(1'b1, 1'b0, 1'b0, 1'b1, 26'h123, 1'b0, 1'b0, 16'h0, 1'b0, 8'd0)};
      tbl[1] = '{r0:1'b0, a0:26'h0, r1:1'b0, a1:26'h0, wr:1'b0, rdv:1'b0, rd:16'h0,
                 exp:mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h123, 1'b0, 1'b0, 16'h0, 1'b0, 8'd0)};
      tbl[2] = tbl[1];
      tbl[3] = tbl[1];
      tbl[4] = '{r0:1'b0, a0:26'h0, r1:1'b0, a1:26'h0, wr:1'b0, rdv:1'b1, rd:16'hBEEF,
                 exp:mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h123, 1'b1, 1'b0, 16'hBEEF, 1'b0, 8'd0)};
      tbl[5] = '{r0:1'b0, a0:26'h0, r1:1'b0, a1:26'h0, wr:1'b0, rdv:1'b0, rd:16'h0,
                 exp:mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h123, 1'b0, 1'b0, 16'hBEEF, 1'b0, 8'd0)};
      tbl[6] = '{r0:1'b0, a0:26'h0, r1:1'b0, a1:26'h0, wr:1'b0, rdv:1'b1, rd:16'h1111,
                 exp:mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h123, 1'b0, 1'b0, 16'hBEEF, 1'b0, 8'd0)};

      reset_n = 1'b0;
      drive(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
      repeat (2) @(negedge clock);
      check("reset", rst_v);
      reset_n = 1'b1;
      @(negedge clock);
      check("reset_idle", rst_v);

      // single read from requester 0, then a stray readdata_valid while idle
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1, tbl[i].wr, tbl[i].rdv, tbl[i].rd);
         @(negedge clock);
         check($sformatf("single[%0d]", i), tbl[i].exp);
      end

      // fairness with both requesters held high
      do_reset();
      r0h = 1'b1; r1h = 1'b1; guard = 0;
      drive(r0h, 26'h10, r1h, 26'h20, 1'b0, 1'b1, 16'h5A5A);
      while ((r0h || r1h) && guard < 100) begin
         @(negedge clock); guard++;
         if (req0_ack) begin grants.push_back(0); if (grants.size() >= 8) r0h = 1'b0; end
         if (req1_ack) begin grants.push_back(1); if (grants.size() >= 8) r1h = 1'b0; end
         drive(r0h, 26'h10, r1h, 26'h20, 1'b0, 1'b1, 16'h5A5A);
      end
      check_int("fair_count", grants.size(), 9);
      for (int k = 0; k < 8; k++)
         check_int($sformatf("fair_grant[%0d]", k), (k < grants.size()) ? grants[k] : -1, k % 2);
      repeat (3) @(negedge clock);

      // waitrequest stall on requester 1
      drive(1'b0, 26'h0, 1'b1, 26'h2AAAAAA, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      check("stall[0]", mk(1'b0, 1'b1, 1'b0, 1'b1, 26'h2AAAAAA, 1'b0, 1'b0, 16'h5A5A, 1'b0, 8'd0));
      drive(1'b0, 26'h0, 1'b0, 26'h2AAAAAA, 1'b1, 1'b0, 16'h0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         check($sformatf("stall[%0d]", k),
               mk(1'b0, 1'b0, 1'b0, 1'b1, 26'h2AAAAAA, 1'b0, 1'b0, 16'h5A5A, 1'b0, 8'd0));
         if (k == 5) sdram_waitrequest = 1'b0;
      end
      @(negedge clock);
      check("stall_accept", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h2AAAAAA, 1'b0, 1'b0, 16'h5A5A, 1'b0, 8'd0));
      sdram_readdata_valid = 1'b1; sdram_readdata = 16'h1234;
      @(negedge clock);
      check("stall_rsp", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h2AAAAAA, 1'b0, 1'b1, 16'h1234, 1'b0, 8'd0));
      sdram_readdata_valid = 1'b0;
      @(negedge clock);

      // timeout after four WAIT_DATA cycles, then a late readdata_valid
      drive(1'b1, 26'h55, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      check("to_issue", mk(1'b1, 1'b0, 1'b0, 1'b1, 26'h55, 1'b0, 1'b0, 16'h1234, 1'b0, 8'd0));
      req0_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         check($sformatf("to_wait[%0d]", k),
               mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h55, 1'b0, 1'b0, 16'h1234, 1'b0, 8'd0));
      end
      @(negedge clock);
      check("to_rsp", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h55, 1'b1, 1'b0, 16'h0, 1'b1, 8'd1));
      sdram_readdata_valid = 1'b1; sdram_readdata = 16'hBEEF;
      @(negedge clock);
      check("to_late", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h55, 1'b0, 1'b0, 16'h0, 1'b1, 8'd1));
      sdram_readdata_valid = 1'b0;

      // data on the accepting edge
      drive(1'b0, 26'h0, 1'b1, 26'h77, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      check("se_issue", mk(1'b0, 1'b1, 1'b0, 1'b1, 26'h77, 1'b0, 1'b0, 16'h0, 1'b1, 8'd1));
      drive(1'b0, 26'h0, 1'b0, 26'h77, 1'b0, 1'b1, 16'hCAFE);
      @(negedge clock);
      check("se_rsp", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h77, 1'b0, 1'b1, 16'hCAFE, 1'b0, 8'd1));
      sdram_readdata_valid = 1'b0;
      @(negedge clock);

      // data on the timeout edge wins over the timeout
      drive(1'b1, 26'h88, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      req0_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         if (k == 4) begin sdram_readdata_valid = 1'b1; sdram_readdata = 16'hD00D; end
      end
      @(negedge clock);
      check("te_rsp", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'h88, 1'b1, 1'b0, 16'hD00D, 1'b0, 8'd1));
      sdram_readdata_valid = 1'b0;
      @(negedge clock);

      // asynchronous reset in the middle of WAIT_DATA
      drive(1'b1, 26'h99, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      req0_valid = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check("async_reset", rst_v);
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b0, 26'h0, 1'b1, 26'hAB, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      check("post_rst_req1", mk(1'b0, 1'b1, 1'b0, 1'b1, 26'hAB, 1'b0, 1'b0, 16'h0, 1'b0, 8'd0));
      drive(1'b0, 26'h0, 1'b0, 26'hAB, 1'b0, 1'b1, 16'h4321);
      @(negedge clock);
      check("post_rst_rsp1", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'hAB, 1'b0, 1'b1, 16'h4321, 1'b0, 8'd0));
      drive(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      drive(1'b1, 26'hC0, 1'b1, 26'hC1, 1'b0, 1'b0, 16'h0);
      @(negedge clock);
      check("tie_grant0", mk(1'b1, 1'b0, 1'b0, 1'b1, 26'hC0, 1'b0, 1'b0, 16'h4321, 1'b0, 8'd0));
      drive(1'b0, 26'h0, 1'b1, 26'hC1, 1'b0, 1'b1, 16'h0001);
      @(negedge clock);
      check("tie_rsp0", mk(1'b0, 1'b0, 1'b1, 1'b0, 26'hC0, 1'b1, 1'b0, 16'h0001, 1'b0, 8'd0));
      sdram_readdata_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("tie_grant1", mk(1'b0, 1'b1, 1'b0, 1'b1, 26'hC1, 1'b0, 1'b0, 16'h0001, 1'b0, 8'd0));
      drive(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b1, 16'h0002);
      repeat (2) @(negedge clock);
      sdram_readdata_valid = 1'b0;
      @(negedge clock);

      // timeout_count saturates at 255
      for (int i = 0; i < 260; i++) begin
         drive(1'b1, 26'(i), 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
         guard = 0;
         do begin @(negedge clock); guard++; end while (!req0_ack && guard < 10);
         check_int("sat_ack", int'(req0_ack), 1);
         drive(1'b0, 26'(i), 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
         guard = 0;
         while (!rsp0_valid && guard < 20) begin @(negedge clock); guard++; end
         check_int("sat_rsp", int'(rsp0_valid), 1);
         if (!rsp0_valid) break;
         check_int($sformatf("sat_tcount[%0d]", i), int'(timeout_count), (i + 1 > 255) ? 255 : i + 1);
         @(negedge clock);
      end

      // randomized traffic against the reference model
      do_reset();
      model_reset();
      p0 = 1'b0; p1 = 1'b0; ra0 = 26'h0; ra1 = 26'h0;
      for (int c = 0; c < 3000; c++) begin
         check($sformatf("rand[%0d]", c), mk(m_ack0, m_ack1, m_rn, m_cs, m_addr, m_v0, m_v1, m_data, m_err, m_tc));
         if (m_ack0) p0 = 1'b0;
         if (m_ack1) p1 = 1'b0;
         if (!p0 && $urandom_range(2) == 0) begin p0 = 1'b1; ra0 = 26'($urandom); end
         if (!p1 && $urandom_range(2) == 0) begin p1 = 1'b1; ra1 = 26'($urandom); end
         wr  = ($urandom_range(2) == 0);
         rdv = ($urandom_range(3) == 0);
         rd  = 16'($urandom);
         drive(p0, ra0, p1, ra1, wr, rdv, rd);
         model_step(p0, p1, ra0, ra1, wr, rdv, rd);
         @(negedge clock);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
